mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between the fetch stage (instruction side, I) and the
//  memory stage (data side, D) of the 5-stage RV64 pipeline. Arbitrates requests, sequences one
//  bus transaction at a time, returns read data per requester, and flags bus timeouts for traps.
//  Sits in top between fetch/memory stages and the external memory bus.
// PARAMETERS
//  MAX_STARVE  4    consecutive D grants while I_REQ pending before I is forced to win
//  TIMEOUT     255  cycles in BUSY without M_READY before transaction ends with error
//  CNT_W       8    width of timeout counter (must hold TIMEOUT)
// PORTS
//  CLK       in   1   clock, all state on rising edge
//  RESET     in   1   asynchronous, active-low reset
//  I_REQ     in   1   fetch read request, held until I_GNT
//  I_ADDR    in   64  fetch address (bit 2 selects word of 64-bit beat)
//  I_FLUSH   in   1   pipeline flush/redirect; squashes pending/in-flight fetch
//  I_GNT     out  1   fetch request accepted this cycle
//  I_RVALID  out  1   fetch data valid (1-cycle pulse)
//  I_RDATA   out  32  fetched instruction
//  I_ERR     out  1   with I_RVALID: bus timeout (fetch access fault)
//  D_REQ     in   1   data request, held until D_GNT
//  D_WE      in   1   1=store 0=load
//  D_SIZE    in   2   0=B 1=H 2=W 3=D, passed through
//  D_ADDR    in   64  data address
//  D_WDATA   in   64  store data
//  D_GNT     out  1   data request accepted this cycle
//  D_RVALID  out  1   data transaction complete (loads and stores), 1-cycle pulse
//  D_RDATA   out  64  load data
//  D_ERR     out  1   with D_RVALID: bus timeout (load/store access fault)
//  M_REQ     out  1   bus request, held until M_READY
//  M_WE      out  1   bus write enable
//  M_SIZE    out  2   bus access size (3 for fetch)
//  M_ADDR    out  64  bus address (fetch: I_ADDR with [2:0] cleared)
//  M_WDATA   out  64  bus write data
//  M_READY   in   1   bus completes transaction this cycle
//  M_RDATA   in   64  bus read data, valid with M_READY
// BEHAVIOUR
//  - Reset (RESET=0, async): state IDLE, all out valids/grants/M_REQ/M_WE=0, data/addr outs=0,
//    starve_cnt=0, tmo_cnt=0, squash=0.
//  - FSM IDLE -> I_BUSY | D_BUSY -> IDLE. One outstanding transaction; no pipelining.
//  - IDLE arbitration (combinational grant, same cycle as request):
//    D_REQ & !(I_REQ & !I_FLUSH & starve_cnt==MAX_STARVE) -> D_GNT=1, latch D fields, go D_BUSY.
//    else I_REQ & !I_FLUSH -> I_GNT=1, latch I_ADDR, go I_BUSY. I_REQ with I_FLUSH is never granted.
//  - Grants only asserted in IDLE; at most one of I_GNT/D_GNT high.
//  - starve_cnt: +1 (saturating at MAX_STARVE) on D grant while I_REQ&!I_FLUSH; cleared on I grant
//    or whenever I_REQ=0.
//  - BUSY: M_REQ=1 and M_* driven from latched fields from the cycle after grant until the cycle
//    M_READY=1 is sampled. On that edge: go IDLE, RVALID pulses next cycle with registered data.
//    Grant-to-RVALID minimum latency = 2 cycles (M_READY on first M_REQ cycle).
//  - I_RDATA = I_ADDR_q[2] ? M_RDATA[63:32] : M_RDATA[31:0]. D_RDATA = M_RDATA (stores: 0).
//  - I_FLUSH during I_BUSY (or on the completion cycle): set squash; bus transaction runs to
//    completion; I_RVALID/I_ERR suppressed; squash cleared on return to IDLE. D side never squashed.
//  - tmo_cnt counts BUSY cycles; at TIMEOUT without M_READY: drop M_REQ, go IDLE, RVALID+ERR pulse
//    next cycle, RDATA=0. M_READY on the same cycle as timeout wins (normal completion).
//  - New grant allowed in the same cycle RVALID pulses (back-to-back, IDLE one cycle).
//  - Reset mid-transaction: immediate return to IDLE, M_REQ drops, no RVALID.
// STRUCTURE
//  - Shared package: FSM state encoding (ST_IDLE/ST_IBUSY/ST_DBUSY), size codes SZ_B..SZ_D.
//  - One sub-module natural: arb_starve_ctr (saturating counter + force-I flag). FSM, latches,
//    timeout counter and response registers stay in this module.
// TESTING
//  1 I_REQ only, I_ADDR=0x1004, M_READY 1st cycle -> I_GNT cycle0, M_ADDR=0x1000, I_RVALID cycle2, I_RDATA=M_RDATA[63:32].
//  2 I_REQ and D_REQ held continuously, M_READY always 1 -> grants D,D,D,D,I repeating (MAX_STARVE=4).
//  3 D store 0x8000 D_WDATA=0xDEADBEEF, M_READY after 3 waits -> M_WE=1 4 cycles, D_RVALID once, D_ERR=0.
//  4 I_FLUSH 1 cycle into I_BUSY -> M transaction completes, no I_RVALID; following D_REQ granted next IDLE.
//  5 M_READY never asserted, TIMEOUT=255 -> M_REQ drops after 255 BUSY cycles, D_RVALID=1 D_ERR=1 D_RDATA=0.
//  6 RESET low mid D_BUSY -> M_REQ=0 asynchronously, no D_RVALID after release, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM encoding,
// access-size codes, bus widths and the latched bus request payload.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned INSN_W = 32;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IBUSY = 2'd1,
        ST_DBUSY = 2'd2
    } arb_state_e;

    typedef enum logic [SIZE_W-1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // One bus transaction as captured at grant time.
    typedef struct packed {
        logic              we;
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Anti-starvation counter for the fetch side. Counts data grants that
// happen while a live fetch request waits; once saturated, force_i_c tells
// the arbiter to give the next IDLE slot to fetch.
//   clk, rst_n        clock / async active-low reset
//   i_req, i_flush    fetch request and flush (flushed requests are not live)
//   i_gnt, d_gnt      grants issued this cycle
//   force_i_c         combinational: fetch must win this cycle
module arb_starve_ctr #(
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_flush,
    input  logic i_gnt,
    input  logic d_gnt,
    output logic force_i_c
);

    localparam int unsigned CW = $clog2(MAX_STARVE + 1);

    logic [CW-1:0] cnt_q;

    // Cleared whenever fetch is not asking or has just been served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (i_gnt || !i_req) begin
            cnt_q <= '0;
        end else if (d_gnt && !i_flush && (cnt_q != CW'(MAX_STARVE))) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign force_i_c = i_req & ~i_flush & (cnt_q == CW'(MAX_STARVE));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch (I) and data
// access (D). One transaction at a time: grant in IDLE, run the bus
// handshake in BUSY, return a registered response pulse the cycle after
// completion. Bus timeouts complete with an error flag.
//   clk, rst_n                         clock / async active-low reset
//   i_req/i_addr/i_flush -> i_gnt      fetch request side (grant combinational)
//   i_rvalid/i_rdata/i_err             fetch response pulse
//   d_req/d_we/d_size/d_addr/d_wdata   data request side -> d_gnt (combinational)
//   d_rvalid/d_rdata/d_err             data response pulse
//   m_req/m_we/m_size/m_addr/m_wdata   bus request, held until m_ready
//   m_ready/m_rdata                    bus completion and read data
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_STARVE = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [INSN_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [SIZE_W-1:0] d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              m_req,
    output logic              m_we,
    output logic [SIZE_W-1:0] m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_e         state_q, state_d;
    bus_req_t           req_q;
    logic               word_sel_q;
    logic               squash_q;
    logic [CNT_W-1:0]   tmo_q;
    logic               force_i_c;
    logic               done_c;
    logic               unused_addr_bits;

    // Instruction fetch is word-granular inside an aligned 64-bit beat.
    assign unused_addr_bits = ^i_addr[1:0];

    arb_starve_ctr #(
        .MAX_STARVE (MAX_STARVE)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_flush   (i_flush),
        .i_gnt     (i_gnt),
        .d_gnt     (d_gnt),
        .force_i_c (force_i_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grants and completion detect.
    always_comb begin
        state_d = state_q;
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_req && !force_i_c) begin
                    d_gnt   = 1'b1;
                    state_d = ST_DBUSY;
                end else if (i_req && !i_flush) begin
                    i_gnt   = 1'b1;
                    state_d = ST_IBUSY;
                end
            end
            ST_IBUSY, ST_DBUSY: begin
                // m_ready on the timeout cycle still counts as a normal completion.
                if (m_ready || (tmo_q == CNT_W'(TIMEOUT - 1))) begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the granted request; fetch always reads a full aligned beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= '0;
            word_sel_q <= 1'b0;
        end else if (d_gnt) begin
            req_q <= '{we: d_we, size: d_size, addr: d_addr, wdata: d_wdata};
        end else if (i_gnt) begin
            req_q      <= '{we: 1'b0, size: SZ_D, addr: {i_addr[ADDR_W-1:3], 3'b000},
                            wdata: {DATA_W{1'b0}}};
            word_sel_q <= i_addr[2];
        end
    end

    // Timeout counter and fetch squash tracking across a busy period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q    <= '0;
            squash_q <= 1'b0;
        end else if ((state_q == ST_IDLE) || done_c) begin
            tmo_q    <= '0;
            squash_q <= 1'b0;
        end else begin
            tmo_q <= tmo_q + CNT_W'(1);
            if ((state_q == ST_IBUSY) && i_flush) begin
                squash_q <= 1'b1;
            end
        end
    end

    // Response registers: one-cycle pulse after completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            i_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (done_c && (state_q == ST_IBUSY)) begin
                // A flush on the completion cycle squashes just like an earlier one.
                i_rvalid <= !(squash_q || i_flush);
                i_err    <= !m_ready && !(squash_q || i_flush);
                i_rdata  <= !m_ready ? '0 :
                            (word_sel_q ? m_rdata[DATA_W-1:INSN_W] : m_rdata[INSN_W-1:0]);
            end
            if (done_c && (state_q == ST_DBUSY)) begin
                d_rvalid <= 1'b1;
                d_err    <= !m_ready;
                d_rdata  <= (m_ready && !req_q.we) ? m_rdata : '0;
            end
        end
    end

    // Bus side is driven straight from the latched request.
    assign m_req   = (state_q != ST_IDLE);
    assign m_we    = m_req & req_q.we;
    assign m_size  = req_q.size;
    assign m_addr  = req_q.addr;
    assign m_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int MAX_STARVE = 4;
    localparam int TIMEOUT    = 255;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_flush;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [1:0]  m_size;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic        m_ready;
    logic [63:0] m_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .MAX_STARVE (MAX_STARVE),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_flush  (i_flush),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_size   (d_size),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_size   (m_size),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        i_req = 0; i_flush = 0; d_req = 0; d_we = 0; m_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_addr = '0; d_size = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        rst_n = 0;
        #12;
        checks++;
        if ({m_req, m_we, i_rvalid, d_rvalid, i_gnt, d_gnt, i_err, d_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 00000000",
                     {m_req, m_we, i_rvalid, d_rvalid, i_gnt, d_gnt, i_err, d_err});
        end
        checks++;
        if ((m_addr | m_wdata | d_rdata | {32'h0, i_rdata} | {62'h0, m_size}) !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wdata=%h drdata=%h irdata=%h size=%0d required 0",
                     m_addr, m_wdata, d_rdata, i_rdata, m_size);
        end
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_fetch_basic();
        logic [63:0] rd;
        rd = rand64();
        step();
        i_req = 1; i_addr = 64'h1004; #1;
        checks++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            errors++; $display("FAIL fetch_gnt got i=%b d=%b required i=1 d=0", i_gnt, d_gnt);
        end
        step();
        i_req = 0; m_ready = 1; m_rdata = rd; #1;
        checks++;
        if (m_req !== 1'b1 || m_addr !== 64'h1000 || m_size !== 2'd3 || m_we !== 1'b0) begin
            errors++;
            $display("FAIL fetch_bus got req=%b addr=%h size=%0d we=%b required 1 1000 3 0",
                     m_req, m_addr, m_size, m_we);
        end
        step();
        m_ready = 0; #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== rd[63:32] || i_err !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rsp got v=%b data=%h err=%b required 1 %h 0",
                     i_rvalid, i_rdata, i_err, rd[63:32]);
        end
        step();
        #1;
        checks++;
        if (i_rvalid !== 1'b0 || m_req !== 1'b0) begin
            errors++; $display("FAIL fetch_pulse got v=%b req=%b required 0 0", i_rvalid, m_req);
        end
    endtask

    task automatic test_starve();
        int ngr;
        bit exp_i;
        ngr = 0;
        step();
        i_req = 1; i_addr = rand64(); d_req = 1; d_we = 0; d_size = 2'd3;
        d_addr = rand64(); d_wdata = rand64(); m_ready = 1; m_rdata = rand64();
        for (int cyc = 0; cyc < 60 && ngr < 15; cyc++) begin
            #1;
            checks++;
            if (i_gnt && d_gnt) begin
                errors++; $display("FAIL starve_both got i=1 d=1 required at most one");
            end
            if (i_gnt || d_gnt) begin
                exp_i = ((ngr % (MAX_STARVE + 1)) == MAX_STARVE);
                checks++;
                if (i_gnt !== exp_i) begin
                    errors++;
                    $display("FAIL starve_order grant %0d got i=%b d=%b required i=%b",
                             ngr, i_gnt, d_gnt, exp_i);
                end
                ngr++;
            end
            if (ngr < 15) step();
        end
        checks++;
        if (ngr !== 15) begin
            errors++; $display("FAIL starve_count got %0d grants required 15", ngr);
        end
        step();
        idle_inputs(); m_ready = 1;
        step();
        m_ready = 0;
        step();
    endtask

    task automatic test_store_wait();
        int we_cycles, rv_cnt;
        we_cycles = 0; rv_cnt = 0;
        step();
        d_req = 1; d_we = 1; d_size = 2'd2; d_addr = 64'h8000; d_wdata = 64'hDEADBEEF; #1;
        checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
            errors++; $display("FAIL store_gnt got d=%b i=%b required 1 0", d_gnt, i_gnt);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            d_req = 0; m_ready = (k == 3); m_rdata = rand64(); #1;
            if (m_we) we_cycles++;
            if (m_req) begin
                checks++;
                if (m_addr !== 64'h8000 || m_wdata !== 64'hDEADBEEF || m_size !== 2'd2) begin
                    errors++;
                    $display("FAIL store_bus got addr=%h wdata=%h size=%0d required 8000 deadbeef 2",
                             m_addr, m_wdata, m_size);
                end
            end
            if (d_rvalid) begin
                rv_cnt++;
                checks++;
                if (d_err !== 1'b0 || d_rdata !== 64'h0 || k !== 4) begin
                    errors++;
                    $display("FAIL store_rsp got err=%b data=%h at %0d required 0 0 at 4",
                             d_err, d_rdata, k);
                end
            end
        end
        m_ready = 0;
        checks++;
        if (we_cycles !== 4 || rv_cnt !== 1) begin
            errors++;
            $display("FAIL store_counts got we=%0d rvalid=%0d required 4 1", we_cycles, rv_cnt);
        end
    endtask

    task automatic test_flush();
        logic [63:0] rd2;
        rd2 = rand64();
        step();
        i_req = 1; i_addr = rand64(); #1;
        checks++;
        if (i_gnt !== 1'b1) begin
            errors++; $display("FAIL flush_gnt got %b required 1", i_gnt);
        end
        step();
        i_req = 0; i_flush = 1; m_ready = 0; #1;
        checks++;
        if (m_req !== 1'b1) begin
            errors++; $display("FAIL flush_busy got %b required 1", m_req);
        end
        step();
        i_flush = 0; d_req = 1; d_we = 0; d_size = 2'd1; d_addr = rand64();
        m_ready = 1; m_rdata = rand64(); #1;
        checks++;
        if (d_gnt !== 1'b0 || m_req !== 1'b1) begin
            errors++; $display("FAIL flush_nogrant got gnt=%b req=%b required 0 1", d_gnt, m_req);
        end
        step();
        m_ready = 0; #1;
        checks++;
        if (i_rvalid !== 1'b0 || d_gnt !== 1'b1) begin
            errors++;
            $display("FAIL flush_suppress got ivalid=%b dgnt=%b required 0 1", i_rvalid, d_gnt);
        end
        step();
        d_req = 0; m_ready = 1; m_rdata = rd2; #1;
        checks++;
        if (m_addr !== d_addr || m_size !== 2'd1) begin
            errors++; $display("FAIL flush_dbus got %h required %h", m_addr, d_addr);
        end
        step();
        m_ready = 0; #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== rd2 || i_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drsp got v=%b data=%h iv=%b required 1 %h 0",
                     d_rvalid, d_rdata, i_rvalid, rd2);
        end
        step();
    endtask

    // ready_at is the BUSY cycle index on which m_ready rises (-1: never).
    task automatic test_timeout(input int ready_at);
        int nreq, seen;
        logic [63:0] rd;
        nreq = 0; seen = -1; rd = rand64();
        step();
        d_req = 1; d_we = 0; d_size = 2'd3; d_addr = rand64(); #1;
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL tmo_gnt got %b required 1", d_gnt);
        end
        for (int k = 0; k < 300 && seen < 0; k++) begin
            step();
            d_req = 0; m_ready = (k == ready_at); m_rdata = rd; #1;
            if (m_req) nreq++;
            if (d_rvalid) begin
                seen = k;
                checks++;
                if (ready_at < 0 && (d_err !== 1'b1 || d_rdata !== 64'h0)) begin
                    errors++;
                    $display("FAIL tmo_rsp got err=%b data=%h required 1 0", d_err, d_rdata);
                end
                if (ready_at >= 0 && (d_err !== 1'b0 || d_rdata !== rd)) begin
                    errors++;
                    $display("FAIL tmo_edge_rsp got err=%b data=%h required 0 %h",
                             d_err, d_rdata, rd);
                end
            end
        end
        m_ready = 0;
        checks++;
        if (nreq !== TIMEOUT || seen !== TIMEOUT || m_req !== 1'b0) begin
            errors++;
            $display("FAIL tmo_len got mreq_cycles=%0d rvalid_at=%0d req=%b required %0d %0d 0",
                     nreq, seen, m_req, TIMEOUT, TIMEOUT);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        step();
        d_req = 1; d_we = 1; d_size = 2'd3; d_addr = rand64(); d_wdata = rand64(); #1;
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL rstmid_gnt got %b required 1", d_gnt);
        end
        step();
        d_req = 0; m_ready = 0; #1;
        checks++;
        if (m_req !== 1'b1) begin
            errors++; $display("FAIL rstmid_busy got %b required 1", m_req);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (m_req !== 1'b0 || m_we !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got req=%b we=%b required 0 0", m_req, m_we);
        end
        step();
        step();
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            m_ready = 1; #1;
            if (d_rvalid !== 1'b0 || m_req !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL rstmid_quiet got %0d bad cycles required 0", bad);
        end
        step();
        m_ready = 0; i_req = 1; i_addr = rand64(); #1;
        checks++;
        if (i_gnt !== 1'b1) begin
            errors++; $display("FAIL rstmid_idle got %b required 1", i_gnt);
        end
        step();
        i_req = 0; m_ready = 1;
        step();
        m_ready = 0;
        step();
    endtask

    // Transaction-level reference: owner of the port, cycles spent on the bus,
    // and how many data grants fetch has waited through.
    task automatic test_random(input int ncycles);
        int          owner;      // 0 none, 1 fetch, 2 data
        int          busy_n, starve;
        bit          squash, exp_ig, exp_dg, i_ok, done, prev_ig, prev_dg;
        bit          exp_irv, exp_drv, exp_ierr, exp_derr, e_we, e_word;
        logic [31:0] exp_irdata;
        logic [63:0] exp_drdata, e_addr, e_wdata;
        logic [1:0]  e_size;
        owner = 0; busy_n = 0; starve = 0; squash = 0;
        exp_irv = 0; exp_drv = 0; exp_ierr = 0; exp_derr = 0;
        exp_irdata = '0; exp_drdata = '0; e_we = 0; e_word = 0;
        e_addr = '0; e_wdata = '0; e_size = '0;
        prev_ig = 0; prev_dg = 0;
        for (int cyc = 0; cyc < ncycles; cyc++) begin
            step();
            if (!i_req || prev_ig) begin
                i_req = $urandom_range(0, 1); i_addr = rand64();
            end
            if (!d_req || prev_dg) begin
                d_req = $urandom_range(0, 1); d_we = $urandom_range(0, 1);
                d_size = 2'($urandom_range(0, 3)); d_addr = rand64(); d_wdata = rand64();
            end
            i_flush = ($urandom_range(0, 7) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            m_rdata = rand64();
            #1;
            exp_ig = 0; exp_dg = 0;
            if (owner == 0) begin
                i_ok = i_req && !i_flush;
                if (d_req && !(i_ok && starve == MAX_STARVE)) exp_dg = 1;
                else if (i_ok) exp_ig = 1;
            end
            checks++;
            if (i_gnt !== exp_ig || d_gnt !== exp_dg) begin
                errors++;
                $display("FAIL rnd_gnt cyc %0d got i=%b d=%b required i=%b d=%b",
                         cyc, i_gnt, d_gnt, exp_ig, exp_dg);
            end
            checks++;
            if (m_req !== (owner != 0) ||
                (owner != 0 && (m_addr !== e_addr || m_we !== e_we ||
                                m_size !== e_size || m_wdata !== e_wdata))) begin
                errors++;
                $display("FAIL rnd_bus cyc %0d got req=%b addr=%h we=%b size=%0d wdata=%h required req=%b addr=%h we=%b size=%0d wdata=%h",
                         cyc, m_req, m_addr, m_we, m_size, m_wdata,
                         owner != 0, e_addr, e_we, e_size, e_wdata);
            end
            checks++;
            if (i_rvalid !== exp_irv || (exp_irv && (i_rdata !== exp_irdata || i_err !== exp_ierr))) begin
                errors++;
                $display("FAIL rnd_irsp cyc %0d got v=%b data=%h err=%b required v=%b data=%h err=%b",
                         cyc, i_rvalid, i_rdata, i_err, exp_irv, exp_irdata, exp_ierr);
            end
            checks++;
            if (d_rvalid !== exp_drv || (exp_drv && (d_rdata !== exp_drdata || d_err !== exp_derr))) begin
                errors++;
                $display("FAIL rnd_drsp cyc %0d got v=%b data=%h err=%b required v=%b data=%h err=%b",
                         cyc, d_rvalid, d_rdata, d_err, exp_drv, exp_drdata, exp_derr);
            end
            // Advance the reference across the coming clock edge.
            exp_irv = 0; exp_drv = 0;
            if (owner != 0) begin
                busy_n++;
                if (owner == 1 && i_flush) squash = 1;
                done = m_ready || (busy_n == TIMEOUT);
                if (done) begin
                    if (owner == 1) begin
                        exp_irv    = !squash;
                        exp_ierr   = !m_ready;
                        exp_irdata = !m_ready ? 32'h0 : (e_word ? m_rdata[63:32] : m_rdata[31:0]);
                    end else begin
                        exp_drv    = 1;
                        exp_derr   = !m_ready;
                        exp_drdata = (m_ready && !e_we) ? m_rdata : 64'h0;
                    end
                    owner = 0; squash = 0;
                end
            end else if (exp_dg) begin
                owner = 2; busy_n = 0;
                e_addr = d_addr; e_we = d_we; e_size = d_size; e_wdata = d_wdata;
            end else if (exp_ig) begin
                owner = 1; busy_n = 0;
                e_addr = i_addr & ~64'h7; e_we = 0; e_size = 2'd3; e_wdata = '0;
                e_word = i_addr[2];
            end
            if (exp_ig || !i_req) starve = 0;
            else if (exp_dg && !i_flush && starve < MAX_STARVE) starve++;
            prev_ig = exp_ig; prev_dg = exp_dg;
        end
        step();
        idle_inputs(); m_ready = 1;
        step();
        m_ready = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_starve();
        test_store_wait();
        test_flush();
        test_timeout(-1);
        test_timeout(TIMEOUT - 1);
        test_reset_mid();
        test_reset();
        test_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
